switch_debounce_sync: RTL and testbench

Conditioning stage between the board slide switches and the switch PIO input port. Each raw, asynchronous switch line is synchronised into the system clock domain and debounced with its own counter. The block presents a clean level bus that drives the PIO `in_port` directly, plus per-bit one-cycle rise and fall pulses for edge-driven consumers.

---
 rtl/switch_debounce_sync.sv | 99 +++++++++
 tb/tb_switch_debounce_sync.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_sync.sv
// rtl/switch_debounce_sync.sv - switch input synchroniser and per-bit debouncer
//
// Conditions the raw board slide switches for the switch PIO input port.
// Each line is passed through a two-flop synchroniser and then debounced by
// its own counter: a new level is accepted only after the synchronised input
// has disagreed with the current debounced level for DEBOUNCE_CYCLES
// consecutive samples. Any agreeing sample restarts the count from zero.
//
// Parameters:
//   WIDTH           - number of switch lines (matches PIO in_port width)
//   DEBOUNCE_CYCLES - consecutive mismatching samples needed to accept (2 .. 2^24)
//   CNT_W           - counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   clk        in   1      system clock
//   reset      in   1      asynchronous active-high reset
//   sw_raw     in   WIDTH  raw asynchronous switch pins, may bounce
//   sw_stable  out  WIDTH  debounced level, drives PIO in_port
//   sw_rise    out  WIDTH  one-cycle pulse per bit when sw_stable goes 0->1
//   sw_fall    out  WIDTH  one-cycle pulse per bit when sw_stable goes 1->0
//   sw_changed out  1      OR of all rise/fall pulses, registered with them

module switch_debounce_sync #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    // Terminal count: the sample that reaches this value is the
    // DEBOUNCE_CYCLES-th consecutive mismatch, so it triggers acceptance.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] accept;

    // Synchroniser: s1 -> s2 with nothing in between, so the second flop
    // gets a full clock period to resolve metastability. Kept apart from the
    // debounce logic so the pair is easy to identify for timing constraints.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // Acceptance condition per bit: still disagreeing and the counter has
    // already seen DEBOUNCE_CYCLES-1 earlier disagreeing samples.
    always_comb begin
        mismatch = s2 ^ sw_stable;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = mismatch[i] && (cnt[i] == CNT_MAX);
        end
    end

    // Debounce state, counters and registered edge pulses. The pulses are
    // rewritten every cycle, so they default to 0 and last exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_stable  <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_stable  <= (sw_stable & ~accept) | (s2 & accept);
            sw_rise    <= accept & s2;
            sw_fall    <= accept & ~s2;
            sw_changed <= |accept;
            // Counter is cleared on a matching sample or on acceptance, so it
            // never passes CNT_MAX and never wraps.
            for (int i = 0; i < WIDTH; i++) begin
                if (!mismatch[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb/tb_switch_debounce_sync.sv - self-checking bench for switch_debounce_sync

module tb_switch_debounce_sync;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int total = 0;
    int bad   = 0;

    switch_debounce_sync #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] st;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         ch;
    } vec_t;

    vec_t vecs[$];

    // Reference model: raw values captured at each edge, newest first.
    // Before edge e, hist[1] is what the synchroniser output holds, and
    // hist[1..D] are the last D synchronised samples. A bit accepts when all
    // of those samples agree with each other and differ from its level.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_rise, m_fall;
    logic         m_changed;

    task automatic model_reset();
        m_stable  = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = 1'b0;
        hist.delete();
        for (int j = 0; j <= D; j++) hist.push_back('0);
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] acc;
        logic [W-1:0] s;
        acc = '0;
        s   = hist[1];
        for (int b = 0; b < W; b++) begin
            bit same;
            same = 1'b1;
            for (int j = 1; j <= D; j++) begin
                if (hist[j][b] != s[b]) same = 1'b0;
            end
            if (same && (s[b] != m_stable[b])) acc[b] = 1'b1;
        end
        m_rise    = acc & s;
        m_fall    = acc & ~s;
        m_changed = |acc;
        m_stable  = (m_stable & ~acc) | (s & acc);
        hist.push_front(raw);
        void'(hist.pop_back());
    endtask

    function automatic logic [24:0] dut_word();
        return {sw_changed, sw_fall, sw_rise, sw_stable};
    endfunction

    function automatic logic [24:0] mk(input logic c, input logic [7:0] f,
                                       input logic [7:0] r, input logic [7:0] s);
        return {c, f, r, s};
    endfunction

    task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got chg=%0b fall=%h rise=%h stable=%h, want chg=%0b fall=%h rise=%h stable=%h",
                     nm, act[24], act[23:16], act[15:8], act[7:0],
                     exp[24], exp[23:16], exp[15:8], exp[7:0]);
        end
    endtask

    // Drive a raw value after a falling edge, let one rising edge capture it,
    // advance the model, and return at the next falling edge for sampling.
    task automatic tick(input logic [W-1:0] raw);
        sw_raw = raw;
        @(posedge clk);
        model_edge(raw);
        @(negedge clk);
    endtask

    task automatic add_step(input logic [W-1:0] raw, input logic [W-1:0] old_v,
                            input logic [W-1:0] new_v);
        vec_t v;
        for (int i = 0; i < 7; i++) begin
            v.raw  = raw;
            v.st   = (i < 5) ? old_v : new_v;
            v.rise = (i == 5) ? (new_v & ~old_v) : '0;
            v.fall = (i == 5) ? (old_v & ~new_v) : '0;
            v.ch   = (i == 5);
            vecs.push_back(v);
        end
    endtask

    initial begin
        logic [5:0]   bounce;
        logic [W-1:0] cur;
        int           rate;

        reset  = 1'b1;
        sw_raw = '0;
        model_reset();

        // Reset with inputs low: everything 0, and 0 for 20 cycles after.
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", dut_word(), '0);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick('0);
            chk($sformatf("idle%0d", i), dut_word(), '0);
        end

        // Clean steps: bit 0 rises, then 0x0F, then simultaneous 0x0F->0xF0.
        add_step(8'h01, 8'h00, 8'h01);
        add_step(8'h0F, 8'h01, 8'h0F);
        add_step(8'hF0, 8'h0F, 8'hF0);
        foreach (vecs[i]) begin
            tick(vecs[i].raw);
            chk($sformatf("vec%0d", i), dut_word(),
                mk(vecs[i].ch, vecs[i].fall, vecs[i].rise, vecs[i].st));
        end

        // Bounce on bit 3: runs of at most two highs, then held high from
        // the sixth cycle; acceptance five edges after that capture.
        bounce = 6'b101101;
        for (int i = 0; i < 14; i++) begin
            logic b3;
            b3 = (i < 6) ? bounce[5 - i] : 1'b1;
            tick({4'hF, b3, 3'b000});
            if (i < 10)       chk($sformatf("bounce%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hF0));
            else if (i == 10) chk("bounce_accept", dut_word(), mk(1, 8'h00, 8'h08, 8'hF8));
            else              chk($sformatf("bounce_hold%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hF8));
        end

        // Bit 5 boundary: a 3-cycle mismatch is rejected.
        for (int i = 0; i < 10; i++) begin
            tick((i < 3) ? 8'hD8 : 8'hF8);
            chk($sformatf("short%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hF8));
        end
        // A 4-cycle mismatch is accepted, and the immediate return is
        // accepted again after the minimum spacing.
        for (int i = 0; i < 12; i++) begin
            tick((i < 4) ? 8'hD8 : 8'hF8);
            if (i < 5)       chk($sformatf("exact%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hF8));
            else if (i == 5) chk("exact_fall", dut_word(), mk(1, 8'h20, 8'h00, 8'hD8));
            else if (i < 9)  chk($sformatf("exact_low%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hD8));
            else if (i == 9) chk("exact_rise", dut_word(), mk(1, 8'h00, 8'h20, 8'hF8));
            else             chk($sformatf("exact_hi%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hF8));
        end

        // Reset mid-count on bit 2 (counter at 2), released with the switch held.
        for (int i = 0; i < 4; i++) begin
            tick(8'hFC);
            chk($sformatf("midcnt%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hF8));
        end
        reset = 1'b1;
        #1;
        chk("reset_async", dut_word(), '0);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("reset_mid_hold", dut_word(), '0);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(8'hFC);
            if (i < 5)       chk($sformatf("restart%0d", i), dut_word(), '0);
            else if (i == 5) chk("restart_rise", dut_word(), mk(1, 8'h00, 8'hFC, 8'hFC));
            else             chk($sformatf("restart_hold%0d", i), dut_word(), mk(0, 8'h00, 8'h00, 8'hFC));
        end

        // Randomised stimulus against the model, alternating noisy and calm
        // phases, with one reset in the middle.
        cur = 8'hFC;
        for (int c = 0; c < 800; c++) begin
            logic [W-1:0] flip;
            rate = ((c / 40) % 2 == 1) ? 12 : 2;
            flip = '0;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, rate) == 0) flip[b] = 1'b1;
            end
            cur = cur ^ flip;
            if (c == 400) begin
                reset = 1'b1;
                model_reset();
                @(negedge clk);
                chk("rand_reset", dut_word(), '0);
                reset = 1'b0;
            end
            tick(cur);
            chk($sformatf("rand%0d", c), dut_word(), {m_changed, m_fall, m_rise, m_stable});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
